// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage slice: register file geometry and opcode width.
// Operand forwarding is controlled by the DECODE_BYPASS_EN macro in decode_stage.sv.
package decode_stage_pkg;

  localparam int REG_COUNT       = 16;
  localparam int REG_SIZE        = 32;
  localparam int REG_PTR_SIZE    = 4;
  localparam int CORE_ID_SIZE    = 8;
  localparam int DECODE_OPC_SIZE = 4;

  localparam int NUM_SRC         = 3;

endpackage

// File: rtl/decode_stage_reg_scoreboard.sv
// Per-register pending-write scoreboard: one bit per architectural register,
// with set/clear/kill updates and combinational lookups for three sources plus the destination.
module reg_scoreboard #(
  parameter int REG_COUNT    = decode_stage_pkg::REG_COUNT,
  parameter int REG_PTR_SIZE = decode_stage_pkg::REG_PTR_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_set_en,
  input  logic [REG_PTR_SIZE-1:0] i_set_ptr,
  input  logic                    i_clr_en,
  input  logic [REG_PTR_SIZE-1:0] i_clr_ptr,
  input  logic                    i_kill_en,
  input  logic [REG_PTR_SIZE-1:0] i_kill_ptr,
  input  logic [REG_PTR_SIZE-1:0] i_look_0,
  input  logic [REG_PTR_SIZE-1:0] i_look_1,
  input  logic [REG_PTR_SIZE-1:0] i_look_2,
  input  logic [REG_PTR_SIZE-1:0] i_look_dst,
  output logic                    o_pend_0,
  output logic                    o_pend_1,
  output logic                    o_pend_2,
  output logic                    o_pend_dst
);

  logic [REG_COUNT-1:0] r_pending;

  // A new issue to a register wins over a writeback or kill of the same register in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (i_set_en && (i_set_ptr == REG_PTR_SIZE'(i))) begin
          r_pending[i] <= 1'b1;
        end else if ((i_clr_en && (i_clr_ptr == REG_PTR_SIZE'(i))) ||
                     (i_kill_en && (i_kill_ptr == REG_PTR_SIZE'(i)))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign o_pend_0   = r_pending[i_look_0];
  assign o_pend_1   = r_pending[i_look_1];
  assign o_pend_2   = r_pending[i_look_2];
  assign o_pend_dst = r_pending[i_look_dst];

endmodule

// File: rtl/decode_stage.sv
// Decode-to-execute pipeline register with scoreboard hazard stall and writeback forwarding.
// Define DECODE_BYPASS_EN to forward W_result into operands; undefined, pending sources wait for the RF.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int REG_COUNT    = decode_stage_pkg::REG_COUNT,
  parameter int REG_SIZE     = decode_stage_pkg::REG_SIZE,
  parameter int REG_PTR_SIZE = decode_stage_pkg::REG_PTR_SIZE,
  parameter int CORE_ID_SIZE = decode_stage_pkg::CORE_ID_SIZE,
  parameter int OPC_SIZE     = DECODE_OPC_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    FD_valid,
  output logic                    FD_ready,
  input  logic [OPC_SIZE-1:0]     FD_opcode,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_0,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_1,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_src_2,
  input  logic [NUM_SRC-1:0]      FD_uses_src,
  input  logic [REG_PTR_SIZE-1:0] FD_insn_dst,
  input  logic                    FD_wr_en,
  input  logic [REG_SIZE-1:0]     D_src_0_data,
  input  logic [REG_SIZE-1:0]     D_src_1_data,
  input  logic [CORE_ID_SIZE-1:0] D_src_2_data,
  input  logic                    MW_wr_en,
  input  logic [REG_PTR_SIZE-1:0] MW_wr_ptr,
  input  logic [REG_SIZE-1:0]     W_result,
  output logic                    DX_valid,
  input  logic                    DX_ready,
  output logic [OPC_SIZE-1:0]     DX_opcode,
  output logic [REG_SIZE-1:0]     DX_src_0_data,
  output logic [REG_SIZE-1:0]     DX_src_1_data,
  output logic [CORE_ID_SIZE-1:0] DX_src_2_data,
  output logic [REG_PTR_SIZE-1:0] DX_dst,
  output logic                    DX_wr_en
);

  logic                    w_hit_0, w_hit_1, w_hit_2;
  logic                    w_pend_0, w_pend_1, w_pend_2, w_pend_dst;
  logic                    w_blk_0, w_blk_1, w_blk_2;
  logic                    w_waw, w_hazard, w_xfer, w_kill;
  logic [REG_SIZE-1:0]     w_op_0, w_op_1;
  logic [CORE_ID_SIZE-1:0] w_op_2;

  logic                    r_dx_valid;
  logic [OPC_SIZE-1:0]     r_dx_opcode;
  logic [REG_SIZE-1:0]     r_dx_src_0, r_dx_src_1;
  logic [CORE_ID_SIZE-1:0] r_dx_src_2;
  logic [REG_PTR_SIZE-1:0] r_dx_dst;
  logic                    r_dx_wr_en;

`ifdef DECODE_BYPASS_EN
  assign w_hit_0 = MW_wr_en && (MW_wr_ptr == FD_insn_src_0);
  assign w_hit_1 = MW_wr_en && (MW_wr_ptr == FD_insn_src_1);
  assign w_hit_2 = MW_wr_en && (MW_wr_ptr == FD_insn_src_2);
  assign w_op_0  = w_hit_0 ? W_result : D_src_0_data;
  assign w_op_1  = w_hit_1 ? W_result : D_src_1_data;
  assign w_op_2  = w_hit_2 ? W_result[CORE_ID_SIZE-1:0] : D_src_2_data;
`else
  // Without forwarding a source still pending at writeback waits one cycle for the RF copy.
  logic w_unused_result;
  assign w_unused_result = ^W_result;
  assign w_hit_0 = 1'b0;
  assign w_hit_1 = 1'b0;
  assign w_hit_2 = 1'b0;
  assign w_op_0  = D_src_0_data;
  assign w_op_1  = D_src_1_data;
  assign w_op_2  = D_src_2_data;
`endif

  assign w_blk_0  = FD_uses_src[0] && w_pend_0 && !w_hit_0;
  assign w_blk_1  = FD_uses_src[1] && w_pend_1 && !w_hit_1;
  assign w_blk_2  = FD_uses_src[2] && w_pend_2 && !w_hit_2;
  assign w_waw    = FD_wr_en && w_pend_dst && !(MW_wr_en && (MW_wr_ptr == FD_insn_dst));
  assign w_hazard = w_blk_0 || w_blk_1 || w_blk_2 || w_waw;

  assign FD_ready = !reset && !flush && !w_hazard && (!r_dx_valid || DX_ready);
  assign w_xfer   = FD_valid && FD_ready;
  assign w_kill   = flush && r_dx_valid && r_dx_wr_en;

  reg_scoreboard #(
    .REG_COUNT    (REG_COUNT),
    .REG_PTR_SIZE (REG_PTR_SIZE)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (w_xfer && FD_wr_en),
    .i_set_ptr  (FD_insn_dst),
    .i_clr_en   (MW_wr_en),
    .i_clr_ptr  (MW_wr_ptr),
    .i_kill_en  (w_kill),
    .i_kill_ptr (r_dx_dst),
    .i_look_0   (FD_insn_src_0),
    .i_look_1   (FD_insn_src_1),
    .i_look_2   (FD_insn_src_2),
    .i_look_dst (FD_insn_dst),
    .o_pend_0   (w_pend_0),
    .o_pend_1   (w_pend_1),
    .o_pend_2   (w_pend_2),
    .o_pend_dst (w_pend_dst)
  );

  // Flush only drops the valid bit; stale fields are harmless behind DX_valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dx_valid  <= 1'b0;
      r_dx_opcode <= '0;
      r_dx_src_0  <= '0;
      r_dx_src_1  <= '0;
      r_dx_src_2  <= '0;
      r_dx_dst    <= '0;
      r_dx_wr_en  <= 1'b0;
    end else if (flush) begin
      r_dx_valid  <= 1'b0;
    end else if (w_xfer) begin
      r_dx_valid  <= 1'b1;
      r_dx_opcode <= FD_opcode;
      r_dx_src_0  <= w_op_0;
      r_dx_src_1  <= w_op_1;
      r_dx_src_2  <= w_op_2;
      r_dx_dst    <= FD_insn_dst;
      r_dx_wr_en  <= FD_wr_en;
    end else if (DX_ready) begin
      r_dx_valid  <= 1'b0;
    end
  end

  assign DX_valid      = r_dx_valid;
  assign DX_opcode     = r_dx_opcode;
  assign DX_src_0_data = r_dx_src_0;
  assign DX_src_1_data = r_dx_src_1;
  assign DX_src_2_data = r_dx_src_2;
  assign DX_dst        = r_dx_dst;
  assign DX_wr_en      = r_dx_wr_en;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed hazard/handshake scenarios plus a randomized run
// against a pending-set / slot model. Follows DECODE_BYPASS_EN the same way the design does.
module tb_decode_stage;
  import decode_stage_pkg::*;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset, flush, FD_valid, FD_ready, FD_wr_en;
  logic [DECODE_OPC_SIZE-1:0] FD_opcode, DX_opcode;
  logic [REG_PTR_SIZE-1:0] FD_insn_src_0, FD_insn_src_1, FD_insn_src_2, FD_insn_dst;
  logic [2:0]              FD_uses_src;
  logic [REG_SIZE-1:0]     D_src_0_data, D_src_1_data, W_result;
  logic [CORE_ID_SIZE-1:0] D_src_2_data, DX_src_2_data;
  logic                    MW_wr_en, DX_valid, DX_ready, DX_wr_en;
  logic [REG_PTR_SIZE-1:0] MW_wr_ptr, DX_dst;
  logic [REG_SIZE-1:0]     DX_src_0_data, DX_src_1_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of in-flight destinations plus the contents of the single DX slot.
  bit                      m_pend [REG_COUNT];
  bit                      m_dxv;
  logic [DECODE_OPC_SIZE-1:0] m_opc;
  logic [REG_SIZE-1:0]     m_s0, m_s1;
  logic [CORE_ID_SIZE-1:0] m_s2;
  logic [REG_PTR_SIZE-1:0] m_dst;
  bit                      m_wr;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .FD_valid      (FD_valid),
    .FD_ready      (FD_ready),
    .FD_opcode     (FD_opcode),
    .FD_insn_src_0 (FD_insn_src_0),
    .FD_insn_src_1 (FD_insn_src_1),
    .FD_insn_src_2 (FD_insn_src_2),
    .FD_uses_src   (FD_uses_src),
    .FD_insn_dst   (FD_insn_dst),
    .FD_wr_en      (FD_wr_en),
    .D_src_0_data  (D_src_0_data),
    .D_src_1_data  (D_src_1_data),
    .D_src_2_data  (D_src_2_data),
    .MW_wr_en      (MW_wr_en),
    .MW_wr_ptr     (MW_wr_ptr),
    .W_result      (W_result),
    .DX_valid      (DX_valid),
    .DX_ready      (DX_ready),
    .DX_opcode     (DX_opcode),
    .DX_src_0_data (DX_src_0_data),
    .DX_src_1_data (DX_src_1_data),
    .DX_src_2_data (DX_src_2_data),
    .DX_dst        (DX_dst),
    .DX_wr_en      (DX_wr_en)
  );

  function automatic bit fwd(input logic [REG_PTR_SIZE-1:0] src);
    return BYP && MW_wr_en && (MW_wr_ptr == src);
  endfunction

  // An instruction may issue unless one of its used sources or its destination is still in flight
  // (a writeback landing this cycle releases the destination, and the sources only with forwarding).
  function automatic bit model_ready();
    logic [REG_PTR_SIZE-1:0] srcs [3];
    bit stall;
    srcs[0] = FD_insn_src_0;
    srcs[1] = FD_insn_src_1;
    srcs[2] = FD_insn_src_2;
    stall = 1'b0;
    for (int k = 0; k < 3; k++)
      if (FD_uses_src[k] && m_pend[srcs[k]] && !fwd(srcs[k])) stall = 1'b1;
    if (FD_wr_en && m_pend[FD_insn_dst] && !(MW_wr_en && MW_wr_ptr == FD_insn_dst)) stall = 1'b1;
    return !reset && !flush && !stall && (!m_dxv || DX_ready);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < REG_COUNT; r++) m_pend[r] = 1'b0;
    m_dxv = 1'b0; m_opc = '0; m_s0 = '0; m_s1 = '0; m_s2 = '0; m_dst = '0; m_wr = 1'b0;
  endtask

  task automatic model_step();
    bit go;
    go = FD_valid && model_ready();
    if (MW_wr_en) m_pend[MW_wr_ptr] = 1'b0;
    if (flush && m_dxv && m_wr) m_pend[m_dst] = 1'b0;
    if (go && FD_wr_en) m_pend[FD_insn_dst] = 1'b1;
    if (flush) begin
      m_dxv = 1'b0;
    end else if (go) begin
      m_dxv = 1'b1;
      m_opc = FD_opcode;
      m_s0  = fwd(FD_insn_src_0) ? W_result : D_src_0_data;
      m_s1  = fwd(FD_insn_src_1) ? W_result : D_src_1_data;
      m_s2  = fwd(FD_insn_src_2) ? W_result[CORE_ID_SIZE-1:0] : D_src_2_data;
      m_dst = FD_insn_dst;
      m_wr  = FD_wr_en;
    end else if (DX_ready) begin
      m_dxv = 1'b0;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; FD_valid = 1'b0; FD_opcode = '0; FD_uses_src = '0; FD_wr_en = 1'b0;
    FD_insn_src_0 = '0; FD_insn_src_1 = '0; FD_insn_src_2 = '0; FD_insn_dst = '0;
    D_src_0_data = '0; D_src_1_data = '0; D_src_2_data = '0;
    MW_wr_en = 1'b0; MW_wr_ptr = '0; W_result = '0; DX_ready = 1'b1;
  endtask

  task automatic issue(input logic [REG_PTR_SIZE-1:0] s0, input logic [2:0] uses,
                       input logic [REG_PTR_SIZE-1:0] dst, input logic wr,
                       input logic [REG_SIZE-1:0] d0, input logic [REG_SIZE-1:0] d1,
                       input logic [DECODE_OPC_SIZE-1:0] opc);
    FD_valid = 1'b1; FD_insn_src_0 = s0; FD_insn_src_1 = s0 + 1'b1; FD_insn_src_2 = '0;
    FD_uses_src = uses; FD_insn_dst = dst; FD_wr_en = wr; FD_opcode = opc;
    D_src_0_data = d0; D_src_1_data = d1; D_src_2_data = d0[CORE_ID_SIZE-1:0];
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
    n_vec++; if (DX_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_dx_valid got %b want 0", DX_valid); end
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fd_ready got %b want 0", FD_ready); end
    n_vec++; if ({DX_opcode, DX_src_0_data, DX_src_1_data, DX_src_2_data, DX_dst, DX_wr_en} !== '0) begin
      n_err++; $display("[TB] FAIL reset_dx_fields got %h %h %h %h %h %b want all 0",
                        DX_opcode, DX_src_0_data, DX_src_1_data, DX_src_2_data, DX_dst, DX_wr_en);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_release_ready got %b want 1", FD_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(4'd1, 3'b011, 4'd3, 1'b0, 32'd5, 32'd7, 4'h1);
    FD_insn_src_1 = 4'd2;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready0 got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_src_0_data, DX_src_1_data} !== {1'b1, 32'd5, 32'd7}) begin
      n_err++; $display("[TB] FAIL b2b_first got v=%b %0d %0d want v=1 5 7", DX_valid, DX_src_0_data, DX_src_1_data);
    end
    D_src_0_data = 32'd9; D_src_1_data = 32'd11; FD_opcode = 4'h2;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready1 got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_opcode, DX_src_0_data, DX_src_1_data} !== {1'b1, 4'h2, 32'd9, 32'd11}) begin
      n_err++; $display("[TB] FAIL b2b_second got v=%b op=%h %0d %0d want v=1 op=2 9 11",
                        DX_valid, DX_opcode, DX_src_0_data, DX_src_1_data);
    end
    idle();
    advance();
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue(4'd0, 3'b000, 4'd3, 1'b1, 32'd0, 32'd0, 4'h3);
    advance();
    issue(4'd3, 3'b001, 4'd5, 1'b0, 32'h11, 32'd0, 4'h4);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL raw_stall c%0d got %b want 0", c, FD_ready); end
      advance();
    end
    MW_wr_en = 1'b1; MW_wr_ptr = 4'd3; W_result = 32'h2A;
    #1;
`ifdef DECODE_BYPASS_EN
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL raw_bypass_ready got %b want 1", FD_ready); end
    advance();
`else
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL raw_wb_cycle_ready got %b want 0", FD_ready); end
    advance();
    MW_wr_en = 1'b0; D_src_0_data = 32'h2A;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL raw_after_wb_ready got %b want 1", FD_ready); end
    advance();
`endif
    n_vec++; if ({DX_valid, DX_src_0_data} !== {1'b1, 32'h2A}) begin
      n_err++; $display("[TB] FAIL raw_operand got v=%b %h want v=1 2a", DX_valid, DX_src_0_data);
    end
    idle();
    advance();
  endtask

  task automatic test_backpressure();
    do_reset();
    issue(4'd1, 3'b001, 4'd0, 1'b0, 32'hAA, 32'd0, 4'h5);
    advance();
    issue(4'd2, 3'b001, 4'd0, 1'b0, 32'hBB, 32'd0, 4'h6);
    DX_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready c%0d got %b want 0", c, FD_ready); end
      advance();
      n_vec++; if ({DX_valid, DX_src_0_data, DX_opcode} !== {1'b1, 32'hAA, 4'h5}) begin
        n_err++; $display("[TB] FAIL bp_hold c%0d got v=%b %h op=%h want v=1 aa op=5", c, DX_valid, DX_src_0_data, DX_opcode);
      end
    end
    DX_ready = 1'b1;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_ready got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_src_0_data, DX_opcode} !== {1'b1, 32'hBB, 4'h6}) begin
      n_err++; $display("[TB] FAIL bp_next got v=%b %h op=%h want v=1 bb op=6", DX_valid, DX_src_0_data, DX_opcode);
    end
    FD_valid = 1'b0;
    advance();
    n_vec++; if (DX_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_once got %b want 0", DX_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(4'd0, 3'b000, 4'd4, 1'b1, 32'd0, 32'd0, 4'h7);
    DX_ready = 1'b0;
    advance();
    FD_valid = 1'b0; flush = 1'b1;
    #1;
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL flush_ready got %b want 0", FD_ready); end
    advance();
    n_vec++; if (DX_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_dx_valid got %b want 0", DX_valid); end
    flush = 1'b0; DX_ready = 1'b1;
    issue(4'd4, 3'b001, 4'd0, 1'b0, 32'h44, 32'd0, 4'h8);
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_reader_ready got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_src_0_data} !== {1'b1, 32'h44}) begin
      n_err++; $display("[TB] FAIL flush_reader got v=%b %h want v=1 44", DX_valid, DX_src_0_data);
    end
    idle();
    advance();
  endtask

  task automatic test_waw_set_clear();
    do_reset();
    issue(4'd0, 3'b000, 4'd6, 1'b1, 32'd0, 32'd0, 4'h9);
    advance();
    FD_opcode = 4'hA;
    MW_wr_en = 1'b1; MW_wr_ptr = 4'd6;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL waw_sameclr_ready got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_dst, DX_wr_en, DX_opcode} !== {1'b1, 4'd6, 1'b1, 4'hA}) begin
      n_err++; $display("[TB] FAIL waw_issue got v=%b dst=%0d wr=%b op=%h want v=1 dst=6 wr=1 op=a",
                        DX_valid, DX_dst, DX_wr_en, DX_opcode);
    end
    MW_wr_en = 1'b0;
    issue(4'd6, 3'b001, 4'd0, 1'b0, 32'd0, 32'd0, 4'hB);
    #1;
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL waw_reader_ready got %b want 0", FD_ready); end
    advance();
    issue(4'd0, 3'b000, 4'd6, 1'b1, 32'd0, 32'd0, 4'hC);
    #1;
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL waw_writer_ready got %b want 0", FD_ready); end
    advance();
    idle();
    MW_wr_en = 1'b1; MW_wr_ptr = 4'd6;
    advance();
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(4'd0, 3'b000, 4'd5, 1'b1, 32'd0, 32'd0, 4'hD);
    advance();
    issue(4'd5, 3'b001, 4'd0, 1'b0, 32'h55, 32'd0, 4'hE);
    #1;
    n_vec++; if (FD_ready !== 1'b0) begin n_err++; $display("[TB] FAIL areset_prestall got %b want 0", FD_ready); end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
    n_vec++; if ({DX_valid, FD_ready} !== 2'b00) begin
      n_err++; $display("[TB] FAIL areset_immediate got v=%b rdy=%b want 0 0", DX_valid, FD_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (FD_ready !== 1'b1) begin n_err++; $display("[TB] FAIL areset_release_ready got %b want 1", FD_ready); end
    advance();
    n_vec++; if ({DX_valid, DX_src_0_data} !== {1'b1, 32'h55}) begin
      n_err++; $display("[TB] FAIL areset_reader got v=%b %h want v=1 55", DX_valid, DX_src_0_data);
    end
    idle();
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      FD_valid      = ($urandom_range(0, 3) != 0);
      FD_opcode     = DECODE_OPC_SIZE'($urandom);
      FD_insn_src_0 = REG_PTR_SIZE'($urandom_range(0, 3));
      FD_insn_src_1 = REG_PTR_SIZE'($urandom_range(0, 3));
      FD_insn_src_2 = REG_PTR_SIZE'($urandom_range(0, 3));
      FD_uses_src   = 3'($urandom);
      FD_insn_dst   = REG_PTR_SIZE'($urandom_range(0, 3));
      FD_wr_en      = 1'($urandom_range(0, 1));
      D_src_0_data  = REG_SIZE'($urandom);
      D_src_1_data  = REG_SIZE'($urandom);
      D_src_2_data  = CORE_ID_SIZE'($urandom);
      MW_wr_en      = ($urandom_range(0, 2) == 0);
      MW_wr_ptr     = REG_PTR_SIZE'($urandom_range(0, 3));
      W_result      = REG_SIZE'($urandom);
      flush         = ($urandom_range(0, 15) == 0);
      DX_ready      = ($urandom_range(0, 3) != 0);
      #1;
      n_vec++; if (FD_ready !== model_ready()) begin
        n_err++; $display("[TB] FAIL rnd_ready c%0d got %b want %b", c, FD_ready, model_ready());
      end
      advance();
      n_vec++; if (DX_valid !== m_dxv) begin
        n_err++; $display("[TB] FAIL rnd_dx_valid c%0d got %b want %b", c, DX_valid, m_dxv);
      end
      if (m_dxv) begin
        n_vec++;
        if ({DX_opcode, DX_src_0_data, DX_src_1_data, DX_src_2_data, DX_dst, DX_wr_en} !==
            {m_opc, m_s0, m_s1, m_s2, m_dst, m_wr}) begin
          n_err++; $display("[TB] FAIL rnd_dx_slot c%0d got %h %h %h %h %h %b want %h %h %h %h %h %b", c,
                            DX_opcode, DX_src_0_data, DX_src_1_data, DX_src_2_data, DX_dst, DX_wr_en,
                            m_opc, m_s0, m_s1, m_s2, m_dst, m_wr);
        end
      end
    end
    idle();
    advance();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_clear();
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_backpressure();
    test_flush();
    test_waw_set_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
